// File: rtl/pe_dispatch_scheduler_if.sv
// Bundle of dispatch, PE completion and result-stream signals for pe_dispatch_scheduler.
// Optional err output present only when PE_SCHED_ERR_EN is defined.
interface pe_dispatch_scheduler_if #(
    parameter int NUM_PE = 4,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int DATA_W = 32,
    parameter int ROW_W  = (N > 1) ? $clog2(N) : 1,
    parameter int COL_W  = (M > 1) ? $clog2(M) : 1
);
    logic                     job_start;
    logic                     job_ready;
    logic [NUM_PE-1:0]        pe_start;
    logic [NUM_PE-1:0]        pe_done;
    logic [NUM_PE*DATA_W-1:0] pe_result;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [ROW_W-1:0]         out_row;
    logic [COL_W-1:0]         out_col;
    logic                     out_last;
    logic                     all_done;
`ifdef PE_SCHED_ERR_EN
    logic                     err;

    modport master (
        input  job_start, pe_done, pe_result, out_ready,
        output job_ready, pe_start, out_valid, out_data, out_row, out_col, out_last, all_done, err
    );
    modport slave (
        output job_start, pe_done, pe_result, out_ready,
        input  job_ready, pe_start, out_valid, out_data, out_row, out_col, out_last, all_done, err
    );
`else
    modport master (
        input  job_start, pe_done, pe_result, out_ready,
        output job_ready, pe_start, out_valid, out_data, out_row, out_col, out_last, all_done
    );
    modport slave (
        output job_start, pe_done, pe_result, out_ready,
        input  job_ready, pe_start, out_valid, out_data, out_row, out_col, out_last, all_done
    );
`endif
endinterface

// File: rtl/pe_dispatch_scheduler.sv
// Round-robin job dispatch to NUM_PE PEs with in-order retirement of tagged results.
// Optional sticky protocol-error flag enabled by defining PE_SCHED_ERR_EN.
module pe_dispatch_scheduler #(
    parameter int NUM_PE = 4,
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    pe_dispatch_scheduler_if.master bus
);
    localparam int PTR_W = $clog2(NUM_PE);
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(M - 1);

    typedef struct packed {
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [ROW_W-1:0]  row_cnt;
        logic [COL_W-1:0]  col_cnt;
        logic              frozen;
        logic [NUM_PE-1:0] busy;
        logic [NUM_PE-1:0] full;
        logic [NUM_PE-1:0] pe_start;
        logic              out_valid;
        logic [DATA_W-1:0] out_data;
        logic [ROW_W-1:0]  out_row;
        logic [COL_W-1:0]  out_col;
        logic              out_last;
        logic              all_done;
    } ctrl_t;

    ctrl_t st, nxt;

    logic [DATA_W-1:0] slot_data [NUM_PE];
    logic [ROW_W-1:0]  slot_row  [NUM_PE];
    logic [COL_W-1:0]  slot_col  [NUM_PE];

    logic              job_ready;
    logic              accept;
    logic              load;
    logic [NUM_PE-1:0] capture;
    logic [NUM_PE-1:0] wr_onehot;
    logic [NUM_PE-1:0] rd_onehot;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        nxt       = st;
        job_ready = ~st.busy[st.wr_ptr] & ~st.full[st.wr_ptr] & ~st.frozen;
        accept    = bus.job_start & job_ready;
        capture   = bus.pe_done & st.busy;
        load      = st.full[st.rd_ptr] & (~st.out_valid | bus.out_ready);
        wr_onehot = NUM_PE'(1) << st.wr_ptr;
        rd_onehot = NUM_PE'(1) << st.rd_ptr;

        nxt.pe_start = accept ? wr_onehot : '0;
        nxt.busy     = (st.busy & ~capture) | (accept ? wr_onehot : '0);
        nxt.full     = (st.full | capture) & ~(load ? rd_onehot : '0);

        if (accept) begin
            nxt.wr_ptr = st.wr_ptr + PTR_W'(1);
            if (st.col_cnt == LAST_COL) begin
                nxt.col_cnt = '0;
                // The final coordinate has been handed out; hold off dispatch until restart.
                if (st.row_cnt == LAST_ROW) nxt.frozen  = 1'b1;
                else                        nxt.row_cnt = st.row_cnt + ROW_W'(1);
            end else begin
                nxt.col_cnt = st.col_cnt + COL_W'(1);
            end
        end

        if (load) begin
            nxt.out_valid = 1'b1;
            nxt.out_data  = slot_data[st.rd_ptr];
            nxt.out_row   = slot_row[st.rd_ptr];
            nxt.out_col   = slot_col[st.rd_ptr];
            nxt.out_last  = (slot_row[st.rd_ptr] == LAST_ROW) && (slot_col[st.rd_ptr] == LAST_COL);
            nxt.rd_ptr    = st.rd_ptr + PTR_W'(1);
        end else if (bus.out_ready) begin
            nxt.out_valid = 1'b0;
        end

        if (st.out_valid & bus.out_ready & st.out_last) nxt.all_done = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   st <= '0;
        else if (clr) st <= '0;
        else          st <= nxt;
    end

    // NOTE: slot payload has no reset; full[] qualifies it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PE; i++) begin
            if (capture[i]) slot_data[i] <= bus.pe_result[i*DATA_W +: DATA_W];
        end
        if (accept) begin
            slot_row[st.wr_ptr] <= st.row_cnt;
            slot_col[st.wr_ptr] <= st.col_cnt;
        end
    end

`ifdef PE_SCHED_ERR_EN
    logic err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   err <= 1'b0;
        else if (clr) err <= 1'b0;
        else if ((bus.job_start & ~job_ready) | (|(bus.pe_done & ~st.busy))) err <= 1'b1;
    end

    assign bus.err = err;
`endif

    assign bus.job_ready = job_ready;
    assign bus.pe_start  = st.pe_start;
    assign bus.out_valid = st.out_valid;
    assign bus.out_data  = st.out_data;
    assign bus.out_row   = st.out_row;
    assign bus.out_col   = st.out_col;
    assign bus.out_last  = st.out_last;
    assign bus.all_done  = st.all_done;
endmodule

// File: tb/tb_pe_dispatch_scheduler.sv
// Randomized bench for pe_dispatch_scheduler against a job-indexed reference model,
// plus a second N=1/M=1 instance exercised with directed literal checks.
module tb_pe_dispatch_scheduler;
    localparam int NUM_PE = 4;
    localparam int N      = 2;
    localparam int M      = 3;
    localparam int DATA_W = 32;
    localparam int TOT    = N * M;
    localparam int ROW_W  = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W  = (M > 1) ? $clog2(M) : 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic clr1  = 1'b0;

    always #5 clk = ~clk;

    pe_dispatch_scheduler_if #(.NUM_PE(NUM_PE), .N(N), .M(M), .DATA_W(DATA_W)) bus ();
    pe_dispatch_scheduler #(.NUM_PE(NUM_PE), .N(N), .M(M), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
    );

    pe_dispatch_scheduler_if #(.NUM_PE(2), .N(1), .M(1), .DATA_W(DATA_W)) bus1 ();
    pe_dispatch_scheduler #(.NUM_PE(2), .N(1), .M(1), .DATA_W(DATA_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .bus(bus1)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model, indexed by job number k: job k lands in PE k mod NUM_PE, carries
    // tag (k / M, k mod M), and may be dispatched only once job k-NUM_PE has left its slot.
    int                n_acc;
    int                n_load;
    bit                cap [TOT];
    bit                ld  [TOT];
    logic [DATA_W-1:0] res [TOT];
    logic [NUM_PE-1:0] m_start;
    bit                m_valid;
    logic [DATA_W-1:0] m_data;
    logic [ROW_W-1:0]  m_row;
    logic [COL_W-1:0]  m_col;
    bit                m_last;
    bit                m_all_done;
    bit                m_err;

    // Behavioural PE array driven by the bench
    bit pe_act [NUM_PE];
    int pe_job [NUM_PE];
    int pe_cnt [NUM_PE];

    int cur_mode;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic              last;
    } obs_t;

    obs_t              obs[$];
    logic [NUM_PE-1:0] start_obs[$];

    localparam logic [NUM_PE-1:0] EXP_START [TOT] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    localparam logic [ROW_W-1:0]  EXP_ROW   [TOT] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [COL_W-1:0]  EXP_COL   [TOT] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_acc = 0; n_load = 0;
        for (int k = 0; k < TOT; k++) begin cap[k] = 0; ld[k] = 0; res[k] = '0; end
        for (int i = 0; i < NUM_PE; i++) begin pe_act[i] = 0; pe_job[i] = 0; pe_cnt[i] = 0; end
        m_start = '0; m_valid = 0; m_data = '0; m_row = '0; m_col = '0;
        m_last = 0; m_all_done = 0; m_err = 0;
    endtask

    function automatic bit exp_ready();
        if (n_acc >= TOT)   return 1'b0;
        if (n_acc < NUM_PE) return 1'b1;
        return ld[n_acc - NUM_PE];
    endfunction

    function automatic int job_latency(input int k);
        case (cur_mode)
            0:       return 3;
            1:       return (k < 3) ? 10 - 3 * k : int'($urandom_range(1, 6));
            default: return int'($urandom_range(1, 8));
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] job_data(input int k);
        if (cur_mode == 1 && k < 3) return DATA_W'(32'h11 * (k + 1));
        return DATA_W'($urandom);
    endfunction

    task automatic compare_outputs();
        check("job_ready", bus.job_ready, exp_ready());
        check("pe_start",  bus.pe_start,  m_start);
        check("out_valid", bus.out_valid, m_valid);
        check("out_data",  bus.out_data,  m_data);
        check("out_row",   bus.out_row,   m_row);
        check("out_col",   bus.out_col,   m_col);
        check("out_last",  bus.out_last,  m_last);
        check("all_done",  bus.all_done,  m_all_done);
`ifdef PE_SCHED_ERR_EN
        check("err",       bus.err,       m_err);
`endif
    endtask

    // One clock: compare at negedge, drive inputs, then advance the model across the coming edge.
    task automatic cycle(input bit js, input bit ordy, input bit stray_en, input bit do_clr);
        logic [NUM_PE-1:0]        done;
        logic [NUM_PE*DATA_W-1:0] result;
        bit rdy, acc, ldc, hs_last, stray;
        @(negedge clk);
        compare_outputs();
        if (bus.pe_start != '0) start_obs.push_back(bus.pe_start);
        if (bus.out_valid && ordy && !do_clr)
            obs.push_back('{bus.out_data, bus.out_row, bus.out_col, bus.out_last});

        done = '0; stray = 0;
        for (int i = 0; i < NUM_PE; i++) begin
            result[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            if (do_clr) continue;
            if (pe_act[i] && pe_cnt[i] == 0) begin
                done[i] = 1'b1;
                result[i*DATA_W +: DATA_W] = res[pe_job[i]];
            end else if (!pe_act[i] && stray_en && $urandom_range(0, 15) == 0) begin
                done[i] = 1'b1;
                stray   = 1;
            end
        end
        bus.job_start = js;
        bus.out_ready = ordy;
        bus.pe_done   = done;
        bus.pe_result = result;
        clr           = do_clr;

        if (do_clr) begin
            model_reset();
            return;
        end
        rdy     = exp_ready();
        acc     = js && rdy;
        ldc     = (n_load < TOT) && cap[n_load] && (!m_valid || ordy);
        hs_last = m_valid && ordy && m_last;
        if ((js && !rdy) || stray) m_err = 1;

        for (int i = 0; i < NUM_PE; i++) begin
            if (done[i] && pe_act[i]) begin
                cap[pe_job[i]] = 1;
                pe_act[i]      = 0;
            end else if (pe_act[i] && pe_cnt[i] > 0) begin
                pe_cnt[i]--;
            end
        end

        m_start = '0;
        if (acc) begin
            m_start                   = NUM_PE'(1) << (n_acc % NUM_PE);
            pe_act[n_acc % NUM_PE]    = 1;
            pe_job[n_acc % NUM_PE]    = n_acc;
            pe_cnt[n_acc % NUM_PE]    = job_latency(n_acc);
            res[n_acc]                = job_data(n_acc);
            n_acc++;
        end

        if (ldc) begin
            m_valid = 1;
            m_data  = res[n_load];
            m_row   = ROW_W'(n_load / M);
            m_col   = COL_W'(n_load % M);
            m_last  = (n_load == TOT - 1);
            ld[n_load] = 1;
            n_load++;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        if (hs_last) m_all_done = 1;
    endtask

    task automatic run_round(input int mode);
        int cyc, post;
        bit js, ordy, stray_en, do_clr;
        cur_mode = mode;
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        obs.delete();
        start_obs.delete();
        cyc = 0; post = 0;
        while (post < 6 && cyc < 400) begin
            js = 1; ordy = 1; stray_en = 0; do_clr = 0;
            case (mode)
                2: begin
                    js       = ($urandom_range(0, 2) != 0);
                    ordy     = ($urandom_range(0, 3) != 0);
                    stray_en = 1;
                end
                3: ordy = (cyc >= 30);
                4: begin
                    js       = 1'($urandom_range(0, 1));
                    ordy     = 1'($urandom_range(0, 1));
                    stray_en = 1;
                    do_clr   = (cyc == 6);
                end
                default: ;
            endcase
            cycle(js, ordy, stray_en, do_clr);
            if (do_clr) begin obs.delete(); start_obs.delete(); end
            if (mode == 3 && cyc == 25) begin
                check("bp_job_ready", bus.job_ready, 0);
                check("bp_out_valid", bus.out_valid, 1);
                check("bp_out_data",  bus.out_data,  res[0]);
            end
            if (mode == 4 && cyc == 7) begin
                check("clr_job_ready", bus.job_ready, 1);
                check("clr_out_valid", bus.out_valid, 0);
                check("clr_all_done",  bus.all_done,  0);
            end
            if (m_all_done) post++;
            cyc++;
        end
        check($sformatf("round%0d_all_done", mode), bus.all_done, 1);
        check($sformatf("round%0d_retired", mode), obs.size(), TOT);

        if (mode == 0) begin
            check("m0_start_count", start_obs.size(), TOT);
            for (int i = 0; i < start_obs.size() && i < TOT; i++)
                check($sformatf("m0_start%0d", i), start_obs[i], EXP_START[i]);
            for (int i = 0; i < obs.size() && i < TOT; i++) begin
                check($sformatf("m0_row%0d", i),  obs[i].row,  EXP_ROW[i]);
                check($sformatf("m0_col%0d", i),  obs[i].col,  EXP_COL[i]);
                check($sformatf("m0_last%0d", i), obs[i].last, (i == TOT - 1) ? 1 : 0);
            end
        end
        if (mode == 1) begin
            for (int i = 0; i < obs.size() && i < 3; i++)
                check($sformatf("ooo_data%0d", i), obs[i].data, 32'h11 * (i + 1));
        end
        if (mode == 4 && obs.size() > 0) begin
            check("clr_first_row", obs[0].row, 0);
            check("clr_first_col", obs[0].col, 0);
        end
    endtask

    // Single-element matrix on a second instance: one job, out_last on the first result.
    task automatic small_dut_test();
        @(negedge clk);
        check("s_ready0", bus1.job_ready, 1);
        bus1.job_start = 1'b1;
        @(negedge clk);
        bus1.job_start = 1'b0;
        check("s_pe_start", bus1.pe_start, 2'b01);
        check("s_ready1", bus1.job_ready, 0);
        @(negedge clk);
        bus1.pe_done   = 2'b01;
        bus1.pe_result = {32'h0, 32'h0000ABCD};
        @(negedge clk);
        bus1.pe_done = 2'b00;
        for (int i = 0; i < 10 && !bus1.out_valid; i++) @(negedge clk);
        check("s_out_valid", bus1.out_valid, 1);
        check("s_out_data",  bus1.out_data,  32'h0000ABCD);
        check("s_out_last",  bus1.out_last,  1);
        check("s_out_row",   bus1.out_row,   0);
        check("s_out_col",   bus1.out_col,   0);
        bus1.job_start = 1'b1;
        @(negedge clk);
        check("s_all_done",  bus1.all_done,  1);
        check("s_valid_off", bus1.out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s_frozen", bus1.job_ready, 0);
        end
        bus1.job_start = 1'b0;
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        check("s_clr_ready",    bus1.job_ready, 1);
        check("s_clr_all_done", bus1.all_done,  0);
        check("s_clr_last",     bus1.out_last,  0);
    endtask

    initial begin
        bus.job_start  = 1'b0;
        bus.out_ready  = 1'b0;
        bus.pe_done    = '0;
        bus.pe_result  = '0;
        bus1.job_start = 1'b0;
        bus1.out_ready = 1'b1;
        bus1.pe_done   = '0;
        bus1.pe_result = '0;
        cur_mode = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_outputs();
        check("s_reset_valid", bus1.out_valid, 0);
        check("s_reset_done",  bus1.all_done,  0);
        check("s_reset_start", bus1.pe_start,  0);
        rst_n = 1'b1;

        small_dut_test();
        run_round(0);
        run_round(1);
        run_round(3);
        run_round(4);
        for (int r = 0; r < 20; r++) run_round(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
